uart_transmitter: RTL and testbench
===================================

UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 Parameter CLOCK_FREQ, default 50_000_000, input clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115_200, serial bit rate.
REQ-003 Parameter FIFO_DEPTH, default 4, byte buffer entries (power of two, >=2).
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 data_in  input  8  byte to transmit.
REQ-008 data_in_valid  input  1  data_in holds a byte offered for transmission.
REQ-009 data_in_ready  output  1  block accepts data_in this cycle.
REQ-010 serial_out  output  1  UART line: idle high, 8N1, LSB first.
REQ-011 busy  output  1  frame in progress or FIFO non-empty.
REQ-012 fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently buffered.

Function
REQ-013 Bit period SHALL be SYMBOL_EDGE_TIME = CLOCK_FREQ/BAUD_RATE cycles (integer, truncated); each frame SHALL last exactly 10*SYMBOL_EDGE_TIME cycles.
REQ-014 Handshake: a byte SHALL be pushed on every rising edge with data_in_valid && data_in_ready; data_in_ready SHALL equal (fifo_count != FIFO_DEPTH), combinational from state only, never from data_in_valid.
REQ-015 FIFO SHALL be first-in first-out; pointers wrap modulo FIFO_DEPTH; no byte lost or duplicated.
REQ-016 FSM states IDLE, START, DATA, STOP.
REQ-017 IDLE: serial_out=1; if FIFO non-empty, pop head into 8-bit shift register and go to START at the same edge.
REQ-018 START: serial_out=0 for SYMBOL_EDGE_TIME cycles, then DATA.
REQ-019 DATA: serial_out=shift[0]; every SYMBOL_EDGE_TIME cycles shift right; after 8 bits go to STOP.
REQ-020 STOP: serial_out=1 for SYMBOL_EDGE_TIME cycles; at end, if FIFO non-empty pop and go directly to START (no idle gap), else IDLE.
REQ-021 Latency: byte pushed at edge N into empty FIFO with FSM IDLE -> popped at edge N+1 -> serial_out low from edge N+1 onward (start bit visible one cycle after push is registered).
REQ-022 Simultaneous push and pop: fifo_count unchanged; pushed byte queued behind remaining entries; push into empty FIFO in the same cycle as a pop is impossible (pop requires non-empty).
REQ-023 Full: data_in_ready=0, data_in_valid ignored; the pop edge frees a slot and data_in_ready SHALL rise the following cycle.
REQ-024 serial_out SHALL be driven from a flop (glitch-free).
REQ-025 data_in changes while not accepted SHALL have no effect.
REQ-026 busy = (state != IDLE) || (fifo_count != 0).

Reset
REQ-027 While rst_n=0: serial_out=1, FSM=IDLE, fifo_count=0, busy=0, data_in_ready=1, bit and cycle counters 0; effect immediate, not clock-qualified.
REQ-028 Reset mid-frame SHALL abort the frame (serial_out high immediately) and flush the FIFO; no partial byte resumes after release.
REQ-029 First push is accepted on the first rising edge with rst_n=1.

Verification (CLOCK_FREQ=1000, BAUD_RATE=100 -> 10 cycles/bit unless stated)
REQ-030 Single byte 0xA5 pushed into idle block -> serial_out low for 10 cycles, then bits 1,0,1,0,0,1,0,1 at 10 cycles each, then high for 10 cycles; busy falls after 100 cycles.
REQ-031 Push 0x00,0xFF,0x55,0x0F back-to-back with valid held high -> all accepted in 4 consecutive cycles, 4 frames emitted contiguously (400 cycles, no idle gap), in order.
REQ-032 Hold valid high for 6 bytes with FIFO_DEPTH=4 -> data_in_ready drops when fifo_count=4, rises once per frame pop; all 6 bytes transmitted in order, none dropped.
REQ-033 Assert rst_n=0 mid DATA bit 3 of 0x3C with 2 bytes queued -> serial_out=1 and fifo_count=0 immediately; after release line stays high until a new push.
REQ-034 Push on the exact STOP-end pop edge with FIFO at 1 entry -> fifo_count stays 1, next frame starts with no gap, pushed byte follows it.
REQ-035 Default parameters, byte 0x41 -> each bit lasts 434 cycles, frame 4340 cycles.

Source files
------------

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with a small byte FIFO in front of the serializer.
// The line is driven straight from a flop, and a pop on the stop-bit end edge chains frames without an idle gap.
module uart_transmitter #(
  parameter int unsigned CLOCK_FREQ = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [7:0]                   data_in,
  input  logic                         data_in_valid,
  output logic                         data_in_ready,
  output logic                         serial_out,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam int unsigned SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned PTR_W            = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W            = PTR_W + 1;
  localparam int unsigned BAUD_W           = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(SYMBOL_EDGE_TIME - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             r_state;
  logic [BAUD_W-1:0]  r_baud_cnt;
  logic [2:0]         r_bit_cnt;
  logic [7:0]         r_shift;
  logic               r_serial;

  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  logic               w_push;
  logic               w_pop;
  logic               w_not_empty;
  logic               w_baud_done;

  assign w_not_empty   = (r_count != '0);
  assign w_baud_done   = (r_baud_cnt == BAUD_LAST);
  assign data_in_ready = (r_count != CNT_W'(FIFO_DEPTH));
  assign w_push        = data_in_valid && data_in_ready;
  // Pop when idle, or on the last cycle of a stop bit so the next start bit follows immediately.
  assign w_pop         = w_not_empty && ((r_state == IDLE) || ((r_state == STOP) && w_baud_done));

  assign serial_out    = r_serial;
  assign busy          = (r_state != IDLE) || w_not_empty;
  assign fifo_count    = r_count;

  // Byte storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Serializer FSM; r_serial always holds the level of the bit currently on the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_serial   <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          r_serial <= 1'b1;
          if (w_pop) begin
            r_shift    <= r_mem[r_rd_ptr];
            r_serial   <= 1'b0;
            r_baud_cnt <= '0;
            r_state    <= START;
          end
        end
        START: begin
          if (w_baud_done) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_serial   <= r_shift[0];
            r_state    <= DATA;
          end else begin
            r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
          end
        end
        DATA: begin
          if (w_baud_done) begin
            r_baud_cnt <= '0;
            if (r_bit_cnt == 3'd7) begin
              r_serial <= 1'b1;
              r_state  <= STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              r_shift   <= {1'b0, r_shift[7:1]};
              r_serial  <= r_shift[1];
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
          end
        end
        STOP: begin
          if (w_baud_done) begin
            r_baud_cnt <= '0;
            if (w_pop) begin
              r_shift  <= r_mem[r_rd_ptr];
              r_serial <= 1'b0;
              r_state  <= START;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
          end
        end
        default: begin
          r_serial <= 1'b1;
          r_state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: a 10-cycles/bit instance for the functional scenarios
// and a default-parameter instance for the 434-cycles/bit frame length.
module tb_uart_transmitter;

  localparam int T     = 10;
  localparam int T_DEF = 434;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_in;
  logic       data_in_valid;
  logic       data_in_ready;
  logic       serial_out;
  logic       busy;
  logic [2:0] fifo_count;

  logic [7:0] d_data;
  logic       d_valid;
  logic       d_ready;
  logic       d_serial;
  logic       d_busy;
  logic [2:0] d_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_transmitter #(.CLOCK_FREQ(1000), .BAUD_RATE(100), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready), .serial_out(serial_out), .busy(busy), .fifo_count(fifo_count)
  );

  uart_transmitter dut_def (
    .clk(clk), .rst_n(rst_n), .data_in(d_data), .data_in_valid(d_valid),
    .data_in_ready(d_ready), .serial_out(d_serial), .busy(d_busy), .fifo_count(d_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected line level at cycle c of a frame carrying byte b with t cycles per bit.
  function automatic logic exp_bit(input logic [7:0] b, input int c, input int t);
    int idx;
    idx = c / t;
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return b[idx-1];
  endfunction

  // Follows one frame cycle by cycle from frame cycle 'first'; returns on cycle 0 of the next frame.
  task automatic watch_frame(input logic [7:0] b, input int first, input bit dflt);
    int   t;
    logic obs;
    t = dflt ? T_DEF : T;
    for (int c = first; c < 10 * t; c++) begin
      obs = dflt ? d_serial : serial_out;
      checks++;
      if (obs !== exp_bit(b, c, t)) begin
        errors++;
        $display("FAIL frame byte=%h cycle=%0d serial=%b expected=%b", b, c, obs, exp_bit(b, c, t));
      end
      tick();
    end
  endtask

  task automatic test_reset();
    data_in = 8'h00; data_in_valid = 1'b0; d_data = 8'h00; d_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (serial_out !== 1'b1) begin errors++; $display("FAIL reset_serial got=%b exp=1", serial_out); end
    checks++; if (data_in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", data_in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    checks++; if (d_serial !== 1'b1) begin errors++; $display("FAIL reset_def_serial got=%b exp=1", d_serial); end
    rst_n = 1'b1;
  endtask

  // Push lands on the first edge after reset release; start bit appears one cycle later.
  task automatic test_single();
    data_in = 8'hA5; data_in_valid = 1'b1;
    tick();
    data_in_valid = 1'b0; data_in = 8'hFF;
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", fifo_count); end
    checks++; if (serial_out !== 1'b1) begin errors++; $display("FAIL single_idle_line got=%b exp=1", serial_out); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", busy); end
    tick();
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL single_popped got=%0d exp=0", fifo_count); end
    watch_frame(8'hA5, 0, 1'b0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got=%b exp=0", busy); end
    checks++; if (serial_out !== 1'b1) begin errors++; $display("FAIL single_line_end got=%b exp=1", serial_out); end
    repeat (3) tick();
  endtask

  task automatic test_back_to_back();
    data_in = 8'h00; data_in_valid = 1'b1;
    checks++; if (data_in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got=%b exp=1", data_in_ready); end
    tick(); data_in = 8'hFF;
    tick(); data_in = 8'h55;
    tick(); data_in = 8'h0F;
    tick(); data_in_valid = 1'b0; data_in = 8'h99;
    checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL b2b_count got=%0d exp=3", fifo_count); end
    watch_frame(8'h00, 2, 1'b0);
    watch_frame(8'hFF, 0, 1'b0);
    watch_frame(8'h55, 0, 1'b0);
    watch_frame(8'h0F, 0, 1'b0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end got=%b exp=0", busy); end
    repeat (3) tick();
  endtask

  task automatic test_full();
    int k;
    data_in = 8'h11; data_in_valid = 1'b1;
    fork
      begin
        tick(); data_in = 8'h22;
        tick(); data_in = 8'h33;
        tick(); data_in = 8'h44;
        tick(); data_in = 8'h55;
        tick();
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_count got=%0d exp=4", fifo_count); end
        checks++; if (data_in_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%b exp=0", data_in_ready); end
        data_in = 8'h66;
        k = 0;
        while (!data_in_ready && k < 200) begin
          tick();
          k++;
        end
        checks++; if (k != 97) begin errors++; $display("FAIL full_ready_rise cycles=%0d exp=97", k); end
        tick();
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_refill got=%0d exp=4", fifo_count); end
        checks++; if (data_in_ready !== 1'b0) begin errors++; $display("FAIL full_ready2 got=%b exp=0", data_in_ready); end
        data_in_valid = 1'b0;
      end
      begin
        tick(); tick();
        watch_frame(8'h11, 0, 1'b0);
        watch_frame(8'h22, 0, 1'b0);
        watch_frame(8'h33, 0, 1'b0);
        watch_frame(8'h44, 0, 1'b0);
        watch_frame(8'h55, 0, 1'b0);
        watch_frame(8'h66, 0, 1'b0);
      end
    join
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy_end got=%b exp=0", busy); end
    repeat (3) tick();
  endtask

  // Reset asserted between clock edges during data bit 3 of 0x3C with two bytes queued.
  task automatic test_reset_mid();
    data_in = 8'h3C; data_in_valid = 1'b1;
    tick(); data_in = 8'hAA;
    tick(); data_in = 8'hBB;
    tick(); data_in_valid = 1'b0;
    checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL rmid_count got=%0d exp=2", fifo_count); end
    repeat (44) tick();
    checks++; if (serial_out !== 1'b1) begin errors++; $display("FAIL rmid_bit3 got=%b exp=1", serial_out); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (serial_out !== 1'b1) begin errors++; $display("FAIL rmid_serial got=%b exp=1", serial_out); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rmid_count_flush got=%0d exp=0", fifo_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    checks++; if (data_in_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got=%b exp=1", data_in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      tick();
      checks++;
      if (serial_out !== 1'b1) begin errors++; $display("FAIL rmid_post_line cycle=%0d got=%b exp=1", c, serial_out); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_post_busy got=%b exp=0", busy); end
  endtask

  // Push coinciding with the stop-end pop while one byte is queued.
  task automatic test_stop_edge_push();
    data_in = 8'h81; data_in_valid = 1'b1;
    tick(); data_in = 8'h7E;
    tick(); data_in_valid = 1'b0;
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL sep_count got=%0d exp=1", fifo_count); end
    fork
      begin
        watch_frame(8'h81, 0, 1'b0);
        watch_frame(8'h7E, 0, 1'b0);
        watch_frame(8'hC3, 0, 1'b0);
      end
      begin
        repeat (99) tick();
        data_in = 8'hC3; data_in_valid = 1'b1;
        tick();
        data_in_valid = 1'b0;
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL sep_count_edge got=%0d exp=1", fifo_count); end
      end
    join
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sep_busy_end got=%b exp=0", busy); end
    repeat (3) tick();
  endtask

  task automatic test_default();
    d_data = 8'h41; d_valid = 1'b1;
    tick();
    d_valid = 1'b0;
    checks++; if (d_count !== 3'd1) begin errors++; $display("FAIL def_count got=%0d exp=1", d_count); end
    tick();
    watch_frame(8'h41, 0, 1'b1);
    checks++; if (d_busy !== 1'b0) begin errors++; $display("FAIL def_busy_end got=%b exp=0", d_busy); end
    checks++; if (d_serial !== 1'b1) begin errors++; $display("FAIL def_line_end got=%b exp=1", d_serial); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_reset_mid();
    test_stop_edge_push();
    test_default();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
